flash_prog_seq: RTL and testbench
=================================

Name: flash_prog_seq

Overview:
- In-system flash program/erase sequencer and ROM-bus arbiter for the cartridge's 512k parallel flash (29F040-class, JEDEC command set).
- Sits between the bank-mapping logic and the physical rom_a/rom_d/oe_n/we_n/ce_n pins.
- The Atari drives it through CCTL registers at $D5C0..$D5C7. It issues unlock/command write cycles and polls completion with the toggle bit.
- While idle, it passes cartridge-window reads through unchanged.

Parameters:
UNLOCK1_ADDR, 19'h05555, first JEDEC unlock address
UNLOCK2_ADDR, 19'h02AAA, second JEDEC unlock address
REG_SEL, 5'b11000, cart_a[7:3] match selecting the register block ($D5C0..$D5C7)
TIMEOUT_W, 24, width of the poll-pair timeout counter

Ports:
phi2  in  1  system clock; all state updates on posedge
reset_n  in  1  asynchronous active-low reset
cart_a  in  13  cartridge address bus
cart_d_in  in  8  cartridge data bus, write path
cart_d_out  out  8  cartridge read data
cart_d_oe  out  1  drive enable for cart_d_out
cctl_n  in  1  CCTL select, active low
r_w  in  1  1=read, 0=write
s5_n  in  1  $A000 window select, active low
rd5  in  1  window enable from bank logic
map_a  in  19  mapped ROM address from bank logic
rom_a  out  19  flash address
rom_d_in  in  8  flash data in
rom_d_out  out  8  flash data out
rom_d_oe  out  1  flash data drive enable
oe_n, we_n, ce_n  out  1 each  flash strobes, active low
busy  out  1  sequencer owns the flash
err  out  1  sticky error flag

Behaviour:
- Reset values:
  - state IDLE; busy=0, err=0, we_n=1, rom_d_oe=0.
  - Address register 0, data register 0, poll counter 0.
  - Reset mid-operation aborts immediately to IDLE. The flash may still be executing internally; software re-polls the status register.
- Registers. A register access requires ~cctl_n and cart_a[7:3]==REG_SEL; cart_a[2:0] selects:
  - 0/1/2: target address bits [7:0], [15:8], [18:16] (R/W).
  - 3: data byte (R/W).
  - 4: command (write only). 8'h01 program byte; 8'h02 sector erase (64k sector at addr[18:16]); 8'h03 chip erase; 8'hF0 clear err.
  - 5: status (read) = {busy, err, 6'b0}.
  - 6, 7: read 8'hFF, writes ignored.
- Register writes while busy are ignored, except that status is always readable. Unknown command codes are ignored.
- Arbitration:
  - IDLE: rom_a=map_a, ce_n=~(rd5&~s5_n), oe_n=~(rd5&~s5_n&r_w), we_n=1 (combinational pass-through).
  - busy=1: the sequencer drives all flash pins. Window reads (rd5&~s5_n&r_w) return 8'hFF with cart_d_oe=1; the flash is not touched.
- Command start: the posedge capturing a valid command write sets busy; the first bus cycle begins on the next posedge.
- Bus write cycle = 3 phi2 cycles: SETUP (rom_a/rom_d_out valid, rom_d_oe=1, ce_n=0), PULSE (we_n=0), HOLD (we_n=1, address/data held). All strobes are registered.
- Write sequences:
  - Program: (U1,AA), (U2,55), (U1,A0), (addr,data).
  - Sector erase: (U1,AA), (U2,55), (U1,80), (U1,AA), (U2,55), ({addr[18:16],16'h0},30).
  - Chip erase: the same first five writes, then (U1,10).
- Poll loop: states RD0, GAP, RD1, GAP.
  - RD0/RD1 drive ce_n=0, oe_n=0, rom_a=target, and sample rom_d_in at the end of the cycle as t0/t1.
  - t0[6]==t1[6]: operation done → IDLE, busy=0.
  - Still toggling with t1[5]=1: run one more pair. If that pair still toggles → err=1, issue reset write (U1,F0) → IDLE.
  - Poll-pair counter saturating at 2^TIMEOUT_W-1 → err=1, reset write, IDLE.
- err is sticky. It clears only on command F0 or reset. A new command is accepted while err=1.

Test Plan:
- Program: write $D5C0..$D5C3 = 34,12,05,5A; write $D5C4 = 01 → rom bus shows 4 writes (5555/AA, 2AAA/55, 5555/A0, 51234/5A), we_n low exactly 1 cycle each. Flash model toggles DQ6 for 10 polls then stable → busy drops; status reads 8'h00.
- Sector erase with addr[18:16]=3 → sixth write is 30000/30; chip erase → sixth write is 5555/10.
- Window read at $A123 during busy → cart_d_out=8'hFF, ce_n stays 1 from the cart side. After idle, rom_a==map_a and the flash data is returned.
- Model holds DQ5=1 while toggling → err=1, reset write 5555/F0, busy=0, status=8'h40. Command F0 → status 8'h00.
- TIMEOUT_W=4 with a forever-toggling model → err after 15 pairs. Assert reset_n mid-sequence → we_n=1 and busy=0 asynchronously. A command written while busy → no extra bus cycles.

Source files
------------

// File: rtl/flash_prog_seq.sv
// flash_prog_seq
//   In-system program/erase sequencer and ROM-bus arbiter for a 29F040-class
//   parallel flash (JEDEC command set). The Atari reaches it through a block
//   of eight CCTL registers. When the sequencer is idle, cartridge-window
//   reads pass straight through to the flash. While it is busy, the sequencer
//   owns every flash pin: it issues the unlock/command write cycles and then
//   polls for completion with the DQ6 toggle bit.
//
// Ports
//   phi2, reset_n         clock (posedge) / async active-low reset
//   cart_a, cart_d_in     cartridge address and write data
//   cart_d_out, cart_d_oe cartridge read data and its drive enable
//   cctl_n, r_w, s5_n     CCTL select, 1=read/0=write, $A000 window select
//   rd5, map_a            window enable and mapped address from bank logic
//   rom_a, rom_d_in       flash address, flash read data
//   rom_d_out, rom_d_oe   flash write data and its drive enable
//   oe_n, we_n, ce_n      flash strobes (active low)
//   busy, err             sequencer owns flash / sticky error flag
module flash_prog_seq #(
  parameter logic [18:0] UNLOCK1_ADDR = 19'h05555,
  parameter logic [18:0] UNLOCK2_ADDR = 19'h02AAA,
  parameter logic [4:0]  REG_SEL      = 5'b11000,
  parameter int unsigned TIMEOUT_W    = 24
) (
  input  logic        phi2,
  input  logic        reset_n,
  input  logic [12:0] cart_a,
  input  logic [7:0]  cart_d_in,
  output logic [7:0]  cart_d_out,
  output logic        cart_d_oe,
  input  logic        cctl_n,
  input  logic        r_w,
  input  logic        s5_n,
  input  logic        rd5,
  input  logic [18:0] map_a,
  output logic [18:0] rom_a,
  input  logic [7:0]  rom_d_in,
  output logic [7:0]  rom_d_out,
  output logic        rom_d_oe,
  output logic        oe_n,
  output logic        we_n,
  output logic        ce_n,
  output logic        busy,
  output logic        err
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_WSETUP, S_WPULSE, S_WHOLD, S_RD0, S_GAP0, S_RD1, S_GAP1
  } state_t;

  typedef enum logic [1:0] {OP_PROG, OP_SECT, OP_CHIP} op_t;

  localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

  state_t               state_q, state_d;
  op_t                  op_q, op_d;
  logic [18:0]          addr_q;
  logic [7:0]           data_q;
  logic [2:0]           idx_q, idx_d, last_idx;
  logic                 rst_wr_q, rst_wr_d;
  logic                 retry_q, retry_d;
  logic                 err_q, err_set;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 t0_dq6, t1_dq6, t1_dq5;

  // Sequencer-side flash pin values, registered so strobes never glitch.
  logic [18:0] pa_q, pa_d;
  logic [7:0]  pd_q, pd_d;
  logic        pdoe_q, pdoe_d, pce_q, pce_d, poe_q, poe_d, pwe_q, pwe_d;
  logic [26:0] wr_e;

  logic busy_i, reg_sel, reg_rd, reg_wr_idle, cmd_wr, cmd_valid, cmd_start, cmd_clr;
  logic win_sel, win_rd;
  logic unused_bits;

  assign unused_bits = ^cart_a[12:8];

  assign busy_i      = (state_q != S_IDLE);
  assign reg_sel     = ~cctl_n & (cart_a[7:3] == REG_SEL);
  assign reg_rd      = reg_sel & r_w;
  assign reg_wr_idle = reg_sel & ~r_w & ~busy_i;
  assign cmd_wr      = reg_wr_idle & (cart_a[2:0] == 3'd4);
  assign cmd_start   = cmd_wr & cmd_valid;
  assign cmd_clr     = cmd_wr & (cart_d_in == 8'hF0);
  assign win_sel     = rd5 & ~s5_n;
  assign win_rd      = win_sel & r_w;
  assign last_idx    = (op_q == OP_PROG) ? 3'd3 : 3'd5;

  always_comb begin
    op_d      = OP_PROG;
    cmd_valid = 1'b0;
    case (cart_d_in)
      8'h01:   begin op_d = OP_PROG; cmd_valid = 1'b1; end
      8'h02:   begin op_d = OP_SECT; cmd_valid = 1'b1; end
      8'h03:   begin op_d = OP_CHIP; cmd_valid = 1'b1; end
      default: ;
    endcase
  end

  // {address, data} of write number idx in the selected command sequence;
  // rst_wr selects the single read/reset write used after an error.
  function automatic logic [26:0] wr_entry(input op_t op, input logic [2:0] idx,
                                           input logic rst_wr, input logic [18:0] a,
                                           input logic [7:0] d);
    logic [26:0] e;
    e = {UNLOCK1_ADDR, 8'hF0};
    if (!rst_wr) begin
      case (idx)
        3'd0:    e = {UNLOCK1_ADDR, 8'hAA};
        3'd1:    e = {UNLOCK2_ADDR, 8'h55};
        3'd2:    e = {UNLOCK1_ADDR, (op == OP_PROG) ? 8'hA0 : 8'h80};
        3'd3:    e = (op == OP_PROG) ? {a, d} : {UNLOCK1_ADDR, 8'hAA};
        3'd4:    e = {UNLOCK2_ADDR, 8'h55};
        default: e = (op == OP_SECT) ? {a[18:16], 16'h0000, 8'h30} : {UNLOCK1_ADDR, 8'h10};
      endcase
    end
    return e;
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rst_wr_d = rst_wr_q;
    retry_d  = retry_q;
    cnt_d    = cnt_q;
    err_set  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          state_d  = S_START;
          idx_d    = '0;
          rst_wr_d = 1'b0;
          retry_d  = 1'b0;
          cnt_d    = '0;
        end
      end
      S_START:  state_d = S_WSETUP;
      S_WSETUP: state_d = S_WPULSE;
      S_WPULSE: state_d = S_WHOLD;
      S_WHOLD: begin
        if (rst_wr_q) begin
          state_d = S_IDLE;
        end else if (idx_q == last_idx) begin
          state_d = S_RD0;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = S_WSETUP;
        end
      end
      S_RD0:  state_d = S_GAP0;
      S_GAP0: state_d = S_RD1;
      S_RD1:  state_d = S_GAP1;
      S_GAP1: begin
        if (t0_dq6 == t1_dq6) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          // A second toggling pair after DQ5 was seen, or the pair that
          // brings the counter to saturation, ends in a reset write.
          if (retry_q || (cnt_q == CNT_MAX - 1'b1)) begin
            err_set  = 1'b1;
            rst_wr_d = 1'b1;
            state_d  = S_WSETUP;
          end else begin
            if (t1_dq5) retry_d = 1'b1;
            state_d = S_RD0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pin values for the state being entered, so they are registered
    // alongside it.
    wr_e   = wr_entry(op_q, idx_d, rst_wr_d, addr_q, data_q);
    pa_d   = pa_q;
    pd_d   = pd_q;
    pdoe_d = 1'b0;
    pce_d  = 1'b1;
    poe_d  = 1'b1;
    pwe_d  = 1'b1;
    case (state_d)
      S_WSETUP, S_WHOLD: begin
        {pa_d, pd_d} = wr_e;
        pdoe_d = 1'b1;
        pce_d  = 1'b0;
      end
      S_WPULSE: begin
        {pa_d, pd_d} = wr_e;
        pdoe_d = 1'b1;
        pce_d  = 1'b0;
        pwe_d  = 1'b0;
      end
      S_RD0, S_RD1: begin
        pa_d  = addr_q;
        pce_d = 1'b0;
        poe_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge phi2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_PROG;
      addr_q   <= '0;
      data_q   <= '0;
      idx_q    <= '0;
      rst_wr_q <= 1'b0;
      retry_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      t0_dq6   <= 1'b0;
      t1_dq6   <= 1'b0;
      t1_dq5   <= 1'b0;
      pa_q     <= '0;
      pd_q     <= '0;
      pdoe_q   <= 1'b0;
      pce_q    <= 1'b1;
      poe_q    <= 1'b1;
      pwe_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rst_wr_q <= rst_wr_d;
      retry_q  <= retry_d;
      cnt_q    <= cnt_d;
      pa_q     <= pa_d;
      pd_q     <= pd_d;
      pdoe_q   <= pdoe_d;
      pce_q    <= pce_d;
      poe_q    <= poe_d;
      pwe_q    <= pwe_d;
      if (cmd_start) op_q <= op_d;
      if (reg_wr_idle) begin
        case (cart_a[2:0])
          3'd0:    addr_q[7:0]   <= cart_d_in;
          3'd1:    addr_q[15:8]  <= cart_d_in;
          3'd2:    addr_q[18:16] <= cart_d_in[2:0];
          3'd3:    data_q        <= cart_d_in;
          default: ;
        endcase
      end
      if (state_q == S_RD0) t0_dq6 <= rom_d_in[6];
      if (state_q == S_RD1) begin
        t1_dq6 <= rom_d_in[6];
        t1_dq5 <= rom_d_in[5];
      end
      if (err_set)      err_q <= 1'b1;
      else if (cmd_clr) err_q <= 1'b0;
    end
  end

  always_comb begin
    cart_d_out = 8'hFF;
    cart_d_oe  = 1'b0;
    if (reg_rd) begin
      cart_d_oe = 1'b1;
      case (cart_a[2:0])
        3'd0:    cart_d_out = addr_q[7:0];
        3'd1:    cart_d_out = addr_q[15:8];
        3'd2:    cart_d_out = {5'b00000, addr_q[18:16]};
        3'd3:    cart_d_out = data_q;
        3'd5:    cart_d_out = {busy_i, err_q, 6'b000000};
        default: cart_d_out = 8'hFF;
      endcase
    end else if (win_rd) begin
      cart_d_oe  = 1'b1;
      cart_d_out = busy_i ? 8'hFF : rom_d_in;
    end
  end

  assign rom_a     = busy_i ? pa_q  : map_a;
  assign ce_n      = busy_i ? pce_q : ~win_sel;
  assign oe_n      = busy_i ? poe_q : ~win_rd;
  assign we_n      = busy_i ? pwe_q : 1'b1;
  assign rom_d_oe  = busy_i & pdoe_q;
  assign rom_d_out = pd_q;
  assign busy      = busy_i;
  assign err       = err_q;

endmodule

// File: tb/tb_flash_prog_seq.sv
// Testbench for flash_prog_seq: a table of single-cycle register/window
// vectors, then hand-written program, erase, error, timeout and reset
// sequences against a small toggle-bit flash model.
module tb_flash_prog_seq;

  localparam logic [4:0]  RS   = 5'b11000;
  localparam logic [18:0] MAP0 = 19'h12345;
  localparam logic [18:0] U1   = 19'h05555;
  localparam logic [18:0] U2   = 19'h02AAA;

  logic        phi2 = 1'b0;
  logic        reset_n = 1'b0;
  logic [12:0] cart_a;
  logic [7:0]  cart_d_in, cart_d_out;
  logic        cart_d_oe, cctl_n, r_w, s5_n, rd5;
  logic [18:0] map_a, rom_a;
  logic [7:0]  rom_d_in, rom_d_out;
  logic        rom_d_oe, oe_n, we_n, ce_n, busy, err;

  always #5 phi2 = ~phi2;

  flash_prog_seq #(.TIMEOUT_W(4)) dut (
    .phi2(phi2), .reset_n(reset_n), .cart_a(cart_a), .cart_d_in(cart_d_in),
    .cart_d_out(cart_d_out), .cart_d_oe(cart_d_oe), .cctl_n(cctl_n), .r_w(r_w),
    .s5_n(s5_n), .rd5(rd5), .map_a(map_a), .rom_a(rom_a), .rom_d_in(rom_d_in),
    .rom_d_out(rom_d_out), .rom_d_oe(rom_d_oe), .oe_n(oe_n), .we_n(we_n),
    .ce_n(ce_n), .busy(busy), .err(err)
  );

  // Flash model: counts sequencer reads; DQ6 toggles on each read for the
  // first tog_n reads after a command (or forever), otherwise array data.
  int          reads = 0;
  int          strobe_bad = 0;
  int          rbase = 0, wbase = 0, tog_n = 0;
  logic        tog_forever = 1'b0, dq5 = 1'b0;
  logic [31:0] rs;
  logic        toggling;
  logic [26:0] wlog[$];

  assign rs       = 32'(reads - rbase);
  assign toggling = tog_forever || (rs < 32'(tog_n));
  assign rom_d_in = toggling ? {1'b0, rs[0], dq5, 5'b00000} : (rom_a[7:0] ^ 8'h3C);

  always @(posedge phi2) begin
    if (busy && !ce_n && !oe_n) reads <= reads + 1;
    if (!we_n) begin
      wlog.push_back({rom_a, rom_d_out});
      if (ce_n || !rom_d_oe || !oe_n) strobe_bad <= strobe_bad + 1;
    end
  end

  typedef struct {
    logic        cctl_n;
    logic [12:0] a;
    logic        r_w;
    logic [7:0]  d;
    logic        s5_n;
    logic        rd5;
    logic [18:0] map;
    logic        chk_d;
    logic [7:0]  exp_d;
    logic        exp_doe;
    logic [18:0] exp_ra;
    logic        exp_ce;
    logic        exp_oe;
  } vec_t;

  int          nvec = 0, nmis = 0;
  logic [26:0] ew [0:5];

  function automatic vec_t mk(input logic cc, input logic [12:0] a, input logic rw,
                              input logic [7:0] d, input logic s5, input logic r5,
                              input logic [18:0] m, input logic cd, input logic [7:0] ed,
                              input logic edoe, input logic [18:0] era, input logic ece,
                              input logic eoe);
    vec_t v;
    v.cctl_n = cc; v.a = a; v.r_w = rw; v.d = d; v.s5_n = s5; v.rd5 = r5; v.map = m;
    v.chk_d = cd; v.exp_d = ed; v.exp_doe = edoe; v.exp_ra = era; v.exp_ce = ece;
    v.exp_oe = eoe;
    return v;
  endfunction

  function automatic vec_t rv(input logic [2:0] sel, input logic [7:0] exp);
    return mk(1'b0, {5'b0, RS, sel}, 1'b1, 8'h00, 1'b1, 1'b0, MAP0, 1'b1, exp, 1'b1, MAP0, 1'b1, 1'b1);
  endfunction

  function automatic vec_t wv(input logic [2:0] sel, input logic [7:0] d);
    return mk(1'b0, {5'b0, RS, sel}, 1'b0, d, 1'b1, 1'b0, MAP0, 1'b0, 8'h00, 1'b0, MAP0, 1'b1, 1'b1);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_bus();
    cctl_n = 1'b1; r_w = 1'b1; s5_n = 1'b1; rd5 = 1'b0; cart_a = '0; cart_d_in = '0;
  endtask

  // Register tasks start at a negedge and return at the following negedge.
  task automatic reg_write(input logic [2:0] sel, input logic [7:0] d);
    cctl_n = 1'b0; cart_a = {5'b0, RS, sel}; r_w = 1'b0; cart_d_in = d;
    @(negedge phi2);
    idle_bus();
  endtask

  task automatic reg_read(input logic [2:0] sel, input logic [7:0] exp, input string nm);
    cctl_n = 1'b0; cart_a = {5'b0, RS, sel}; r_w = 1'b1;
    #1 chk(nm, {55'b0, cart_d_oe, cart_d_out}, {55'b0, 1'b1, exp});
    @(negedge phi2);
    idle_bus();
  endtask

  task automatic start_cmd(input logic [7:0] c, input int tn, input logic tf, input logic d5);
    tog_n = tn; tog_forever = tf; dq5 = d5; rbase = reads; wbase = wlog.size();
    reg_write(3'd4, c);
  endtask

  task automatic wait_idle(input int max, input string nm);
    int n = 0;
    while (busy && n < max) begin
      @(negedge phi2);
      n++;
    end
    chk(nm, {63'b0, busy}, 64'd0);
  endtask

  task automatic chk_log(input string nm, input int n);
    chk({nm, "_nwr"}, 64'(wlog.size() - wbase), 64'(n));
    for (int i = 0; i < n; i++)
      if (wbase + i < wlog.size())
        chk($sformatf("%s_wr%0d", nm, i), {37'b0, wlog[wbase + i]}, {37'b0, ew[i]});
  endtask

  task automatic set_unlock(input logic [7:0] third);
    ew[0] = {U1, 8'hAA}; ew[1] = {U2, 8'h55}; ew[2] = {U1, third};
    ew[3] = {U1, 8'hAA}; ew[4] = {U2, 8'h55};
  endtask

  initial begin
    vec_t vt[$];
    vec_t v;
    int   n;

    idle_bus();
    map_a = MAP0;
    repeat (3) @(negedge phi2);
    #1 chk("reset_state", {60'b0, busy, err, we_n, rom_d_oe}, {60'b0, 4'b0010});
    @(negedge phi2);
    reset_n = 1'b1;

    vt.push_back(rv(3'd5, 8'h00));
    vt.push_back(wv(3'd0, 8'h34));
    vt.push_back(wv(3'd1, 8'h12));
    vt.push_back(wv(3'd2, 8'hFF));
    vt.push_back(rv(3'd2, 8'h07));
    vt.push_back(wv(3'd2, 8'h05));
    vt.push_back(wv(3'd3, 8'h5A));
    vt.push_back(rv(3'd0, 8'h34));
    vt.push_back(rv(3'd1, 8'h12));
    vt.push_back(rv(3'd2, 8'h05));
    vt.push_back(rv(3'd3, 8'h5A));
    vt.push_back(rv(3'd6, 8'hFF));
    vt.push_back(wv(3'd7, 8'h00));
    vt.push_back(rv(3'd7, 8'hFF));
    vt.push_back(wv(3'd4, 8'h55));
    vt.push_back(rv(3'd5, 8'h00));
    vt.push_back(mk(1'b1, 13'h0123, 1'b1, 8'h00, 1'b0, 1'b1, 19'h02123, 1'b1, 8'h1F, 1'b1, 19'h02123, 1'b0, 1'b0));
    vt.push_back(mk(1'b1, 13'h0123, 1'b0, 8'h77, 1'b0, 1'b1, 19'h02123, 1'b0, 8'h00, 1'b0, 19'h02123, 1'b0, 1'b1));
    vt.push_back(mk(1'b1, 13'h0123, 1'b1, 8'h00, 1'b0, 1'b0, 19'h02123, 1'b0, 8'h00, 1'b0, 19'h02123, 1'b1, 1'b1));
    vt.push_back(mk(1'b0, 13'h00B5, 1'b1, 8'h00, 1'b1, 1'b0, MAP0, 1'b0, 8'h00, 1'b0, MAP0, 1'b1, 1'b1));
    vt.push_back(mk(1'b1, 13'h00C0, 1'b1, 8'h00, 1'b1, 1'b0, MAP0, 1'b0, 8'h00, 1'b0, MAP0, 1'b1, 1'b1));

    foreach (vt[i]) begin
      v = vt[i];
      @(negedge phi2);
      cctl_n = v.cctl_n; cart_a = v.a; r_w = v.r_w; cart_d_in = v.d;
      s5_n = v.s5_n; rd5 = v.rd5; map_a = v.map;
      #1 chk($sformatf("vec%0d", i),
             {31'b0, cart_d_oe, (v.chk_d ? cart_d_out : v.exp_d), rom_a, ce_n, oe_n, we_n, busy, err},
             {31'b0, v.exp_doe, v.exp_d, v.exp_ra, v.exp_ce, v.exp_oe, 1'b1, 1'b0, 1'b0});
    end
    @(negedge phi2);
    idle_bus();
    map_a = MAP0;

    // Program 51234 <- 5A with exact bus-cycle timing.
    start_cmd(8'h01, 10, 1'b0, 1'b0);
    s5_n = 1'b0; rd5 = 1'b1; r_w = 1'b1; map_a = 19'h02123;
    #1 chk("busy_win_rd", {52'b0, busy, we_n, ce_n, cart_d_oe, cart_d_out},
           {52'b0, 4'b1111, 8'hFF});
    @(negedge phi2);
    idle_bus();
    map_a = MAP0;
    #1 chk("prog_setup", {34'b0, rom_a, rom_d_out, rom_d_oe, ce_n, we_n},
           {34'b0, U1, 8'hAA, 3'b101});
    cctl_n = 1'b0; cart_a = {5'b0, RS, 3'd4}; r_w = 1'b0; cart_d_in = 8'h02;
    @(negedge phi2);
    #1 chk("prog_pulse", {35'b0, rom_a, rom_d_out, ce_n, we_n}, {35'b0, U1, 8'hAA, 2'b00});
    cart_a = {5'b0, RS, 3'd0}; cart_d_in = 8'h99;
    @(negedge phi2);
    idle_bus();
    #1 chk("prog_hold", {35'b0, rom_a, rom_d_out, ce_n, we_n}, {35'b0, U1, 8'hAA, 2'b01});
    wait_idle(300, "prog_done");
    set_unlock(8'hA0);
    ew[3] = {19'h51234, 8'h5A};
    chk_log("prog", 4);
    chk("prog_reads", 64'(reads - rbase), 64'd12);
    reg_read(3'd5, 8'h00, "prog_status");
    reg_read(3'd0, 8'h34, "busy_wr_ignored");
    s5_n = 1'b0; rd5 = 1'b1; r_w = 1'b1; map_a = 19'h7ABCD;
    #1 chk("idle_win", {34'b0, rom_a, ce_n, oe_n, cart_d_oe, cart_d_out},
           {34'b0, 19'h7ABCD, 3'b001, 8'hF1});
    @(negedge phi2);
    idle_bus();
    map_a = MAP0;

    // Sector erase, sector 3.
    reg_write(3'd2, 8'h03);
    start_cmd(8'h02, 4, 1'b0, 1'b0);
    wait_idle(300, "sect_done");
    set_unlock(8'h80);
    ew[5] = {19'h30000, 8'h30};
    chk_log("sect", 6);
    chk("sect_reads", 64'(reads - rbase), 64'd6);

    // Chip erase, completes on the first pair.
    start_cmd(8'h03, 0, 1'b0, 1'b0);
    wait_idle(300, "chip_done");
    ew[5] = {U1, 8'h10};
    chk_log("chip", 6);
    chk("chip_reads", 64'(reads - rbase), 64'd2);

    // DQ5 while toggling: one retry pair, then error + reset write.
    start_cmd(8'h01, 0, 1'b1, 1'b1);
    wait_idle(300, "dq5_done");
    set_unlock(8'hA0);
    ew[3] = {19'h31234, 8'h5A};
    ew[4] = {U1, 8'hF0};
    chk_log("dq5", 5);
    chk("dq5_reads", 64'(reads - rbase), 64'd4);
    chk("dq5_err", {63'b0, err}, 64'd1);
    reg_read(3'd5, 8'h40, "dq5_status");
    reg_write(3'd4, 8'hF0);
    reg_read(3'd5, 8'h00, "clr_status");

    // Timeout: 15 toggling pairs at TIMEOUT_W=4.
    start_cmd(8'h01, 0, 1'b1, 1'b0);
    wait_idle(400, "tmo_done");
    chk_log("tmo", 5);
    chk("tmo_reads", 64'(reads - rbase), 64'd30);
    reg_read(3'd5, 8'h40, "tmo_status");
    start_cmd(8'h03, 0, 1'b0, 1'b0);
    chk("cmd_while_err", {63'b0, busy}, 64'd1);
    wait_idle(300, "err_chip_done");
    set_unlock(8'h80);
    ew[5] = {U1, 8'h10};
    chk_log("err_chip", 6);
    reg_read(3'd5, 8'h40, "err_sticky");
    reg_write(3'd4, 8'hF0);
    reg_read(3'd5, 8'h00, "clr2_status");

    // Asynchronous reset during a write pulse.
    start_cmd(8'h01, 10, 1'b0, 1'b0);
    n = 0;
    while (we_n && n < 20) begin
      @(negedge phi2);
      n++;
    end
    chk("rst_saw_we", {63'b0, we_n}, 64'd0);
    #2 reset_n = 1'b0;
    #1 chk("async_rst", {60'b0, we_n, busy, err, rom_d_oe}, {60'b0, 4'b1000});
    @(negedge phi2);
    reset_n = 1'b1;
    reg_read(3'd0, 8'h00, "rst_addr");
    reg_read(3'd5, 8'h00, "rst_status");

    chk("strobe_ok", 64'(strobe_bad), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
